ps2_key_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver. It oversamples the raw `PS2_CLK`/`PS2_DATA` lines on a divided tick, assembles and checks 11-bit frames, and decodes the E0/F0 prefix sequences into single make/break key events. Events are buffered in a small FIFO behind a valid/ready handshake. It sits between the board PS/2 pins and game/display logic, and replaces ad-hoc per-design frame capture.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_frame_rx.sv | 115 +++++++++++
 rtl/ps2_key_receiver.sv | 157 +++++++++++++++
 tb/tb_ps2_key_receiver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key receiver.
//   - Scan-code byte constants for the prefixes and the self-test results.
//   - Decoder state encoding (exposed on the top-level debug port).
//   - Packed key event {ext, brk, code} as stored in the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXTENDED = 8'hE0;
  localparam logic [7:0] PS2_RELEASED = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_ERR  = 8'hFC;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line front end and frame assembler.
//   CLK, RST            board clock, synchronous active-high reset
//   PS2_CLK, PS2_DATA   raw asynchronous keyboard lines
//   BYTE_STB            1-cycle pulse, BYTE_DATA holds a frame that passed checks
//   BYTE_DATA           last good data byte (held)
//   FRAME_ERR           1-cycle pulse on a bad start/stop/parity
//   TIMEOUT             1-cycle pulse when a partial frame is abandoned
module ps2_frame_rx #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FILTER_LEN    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       BYTE_STB,
  output logic [7:0] BYTE_DATA,
  output logic       FRAME_ERR,
  output logic       TIMEOUT
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [DW-1:0] div_cnt;
  logic          filt_clk;
  logic [3:0]    filt_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] tmo_cnt;

  logic s_clk;
  logic s_data;
  logic tick;
  logic fall;
  logic last_bit;
  logic frame_ok;

  assign s_clk  = clk_sync[1];
  assign s_data = data_sync[1];
  assign tick   = (div_cnt == DW'(CLK_DIV - 1));

  // The falling edge is recognised on the tick that delivers the
  // FILTER_LEN-th consecutive low sample, so data is taken on that same tick.
  assign fall     = tick && filt_clk && !s_clk && (filt_cnt == 4'(FILTER_LEN - 1));
  assign last_bit = fall && (bit_cnt == 4'd10);

  // shift[0] = start, shift[8:1] = data, shift[9] = parity; stop is live on s_data.
  assign frame_ok = !shift[0] && s_data && (^shift[9:1]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      div_cnt   <= '0;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tmo_cnt   <= '0;
      BYTE_STB  <= 1'b0;
      BYTE_DATA <= '0;
      FRAME_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      BYTE_STB  <= 1'b0;
      FRAME_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;

      if (tick) begin
        if (s_clk != filt_clk) begin
          if (filt_cnt == 4'(FILTER_LEN - 1)) begin
            filt_clk <= s_clk;
            filt_cnt <= '0;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end else begin
          filt_cnt <= '0;
        end
      end

      if (fall) begin
        tmo_cnt <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            BYTE_STB  <= 1'b1;
            BYTE_DATA <= shift[8:1];
          end else begin
            FRAME_ERR <= 1'b1;
          end
        end else begin
          shift   <= {s_data, shift[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (tick && (bit_cnt != 4'd0)) begin
        if (tmo_cnt == TW'(TIMEOUT_TICKS - 1)) begin
          TIMEOUT <= 1'b1;
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard receiver with prefix decoding and event FIFO.
//   CLK, RST                      board clock, synchronous active-high reset
//   PS2_CLK, PS2_DATA             raw keyboard lines
//   KEY_READY / KEY_VALID         event handshake: an event transfers in every
//                                 cycle where both are high; while KEY_READY is
//                                 low the head event is held stable
//   KEY_CODE, KEY_EXT, KEY_BREAK  head event fields (0 when the FIFO is empty)
//   RAW_CODE, RAW_STB             last good byte incl. prefixes, and its update pulse
//   FRAME_ERR, TIMEOUT, OVERFLOW, BAT_OK, BAT_ERR   1-cycle status pulses
//   DBG_STATE                     current decoder state
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FILTER_LEN    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       KEY_READY,
  output logic       KEY_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_BREAK,
  output logic [7:0] RAW_CODE,
  output logic       RAW_STB,
  output logic       FRAME_ERR,
  output logic       TIMEOUT,
  output logic       OVERFLOW,
  output logic       BAT_OK,
  output logic       BAT_ERR,
  output logic [1:0] DBG_STATE
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       rx_stb;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_frame_rx #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .FILTER_LEN   (FILTER_LEN)
  ) u_frame_rx (
    .CLK      (CLK),
    .RST      (RST),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .BYTE_STB (rx_stb),
    .BYTE_DATA(rx_byte),
    .FRAME_ERR(rx_err),
    .TIMEOUT  (TIMEOUT)
  );

  assign RAW_STB   = rx_stb;
  assign RAW_CODE  = rx_byte;
  assign FRAME_ERR = rx_err;

  // Decoder
  dec_state_t state_q;
  dec_state_t state_d;
  logic       push;
  key_event_t push_ev;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= DEC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    push_ev = '0;
    BAT_OK  = 1'b0;
    BAT_ERR = 1'b0;
    if (rx_err) begin
      state_d = DEC_IDLE;
    end else if (rx_stb) begin
      if (rx_byte == PS2_EXTENDED) begin
        // An E0 anywhere restarts an extended sequence.
        state_d = DEC_EXT;
      end else if (rx_byte == PS2_RELEASED) begin
        // F0 only extends EXT; elsewhere it restarts a plain break.
        state_d = (state_q == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
      end else begin
        state_d      = DEC_IDLE;
        push_ev.code = rx_byte;
        case (state_q)
          DEC_IDLE: begin
            if (rx_byte == PS2_BAT_OK)       BAT_OK  = 1'b1;
            else if (rx_byte == PS2_BAT_ERR) BAT_ERR = 1'b1;
            else                             push    = 1'b1;
          end
          DEC_EXT: begin
            push        = 1'b1;
            push_ev.ext = 1'b1;
          end
          DEC_BRK: begin
            push        = 1'b1;
            push_ev.brk = 1'b1;
          end
          DEC_EXT_BRK: begin
            push        = 1'b1;
            push_ev.ext = 1'b1;
            push_ev.brk = 1'b1;
          end
          default: push = 1'b0;
        endcase
      end
    end
  end

  assign DBG_STATE = state_q;

  // Event FIFO, show-ahead
  key_event_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_push;
  key_event_t  head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = KEY_VALID && KEY_READY;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_ev;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      OVERFLOW <= push && full && !pop;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign KEY_VALID = !empty;
  assign KEY_CODE  = empty ? 8'h00 : head.code;
  assign KEY_EXT   = !empty && head.ext;
  assign KEY_BREAK = !empty && head.brk;

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;

  localparam int CLK_DIV       = 4;
  localparam int TIMEOUT_TICKS = 40;
  localparam int FILTER_LEN    = 2;
  localparam int FIFO_DEPTH    = 4;
  localparam int HALF          = 4;  // ticks per PS/2 clock half-period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] raw_code;
  logic       raw_stb;
  logic       frame_err;
  logic       timeout;
  logic       overflow;
  logic       bat_ok;
  logic       bat_err;
  logic [1:0] dbg_state;

  ps2_key_receiver #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .FILTER_LEN   (FILTER_LEN),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .KEY_READY(key_ready),
    .KEY_VALID(key_valid),
    .KEY_CODE (key_code),
    .KEY_EXT  (key_ext),
    .KEY_BREAK(key_break),
    .RAW_CODE (raw_code),
    .RAW_STB  (raw_stb),
    .FRAME_ERR(frame_err),
    .TIMEOUT  (timeout),
    .OVERFLOW (overflow),
    .BAT_OK   (bat_ok),
    .BAT_ERR  (bat_err),
    .DBG_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending prefixes are two flags; an event is emitted on the first
  // non-prefix byte and the flags clear.
  logic [9:0] exp_q[$];
  logic [7:0] raw_q[$];
  bit m_ext = 0, m_brk = 0, stalled = 0;
  int exp_raw = 0, exp_ferr = 0, exp_tmo = 0, exp_ovf = 0, exp_bok = 0, exp_berr = 0;

  task automatic model_byte(input logic [7:0] b);
    exp_raw++;
    raw_q.push_back(b);
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
      if (!(m_ext && !m_brk_was_only_ext(m_ext))) m_ext = m_ext;
    end else if (!m_ext && !m_brk && b == 8'hAA) begin
      exp_bok++;
    end else if (!m_ext && !m_brk && b == 8'hFC) begin
      exp_berr++;
    end else begin
      if (stalled && exp_q.size() >= FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  // F0 keeps the extended flag only when arriving straight after a lone E0.
  function automatic bit m_brk_was_only_ext(input bit e);
    return e;
  endfunction

  task automatic model_err();
    exp_ferr++;
    m_ext = 0; m_brk = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic wait_ticks(input int n);
    repeat (n * CLK_DIV) @(posedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_ticks(HALF);
      ps2_clk = 1'b0;
      wait_ticks(HALF);
      ps2_clk = 1'b1;
    end
    wait_ticks(HALF);
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input int err);
    logic par;
    par = ~(^b);
    if (err == 1) par = ~par;
    return {(err == 2) ? 1'b0 : 1'b1, par, b, (err == 3) ? 1'b1 : 1'b0};
  endfunction

  // err: 0 clean, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_byte(input logic [7:0] b, input int err);
    if (err == 0) model_byte(b);
    else          model_err();
    send_bits(make_frame(b, err), 11);
  endtask

  // Model update for F0 needs the pre-F0 state, handled here explicitly.
  task automatic send_f0();
    if (m_ext && !m_brk) begin
      exp_raw++; raw_q.push_back(8'hF0); m_brk = 1;
    end else begin
      exp_raw++; raw_q.push_back(8'hF0); m_ext = 0; m_brk = 1;
    end
    send_bits(make_frame(8'hF0, 0), 11);
  endtask

  task automatic send_any(input logic [7:0] b, input int err);
    if (err == 0 && b == 8'hF0) send_f0();
    else                        send_byte(b, err);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cnt_raw = 0, cnt_ferr = 0, cnt_tmo = 0, cnt_ovf = 0, cnt_bok = 0, cnt_berr = 0;
  int stb_cyc = 0, valid_rise_cyc = 0;
  bit prev_valid = 0;
  bit rand_ready = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (raw_stb) begin
        cnt_raw++;
        stb_cyc = cyc;
        check_eq("raw_pending", raw_q.size() != 0, 1);
        if (raw_q.size() != 0) check_eq("raw_code", raw_code, raw_q.pop_front());
      end
      if (frame_err) cnt_ferr++;
      if (timeout)   cnt_tmo++;
      if (overflow)  cnt_ovf++;
      if (bat_ok)    cnt_bok++;
      if (bat_err)   cnt_berr++;
      if (key_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = key_valid;
      if (key_valid && key_ready) begin
        check_eq("evt_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("evt", {key_ext, key_break, key_code}, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 key_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkpoint(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || raw_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    wait_ticks(2);
    check_eq({tag, "_drain"}, exp_q.size() + raw_q.size(), 0);
    check_eq({tag, "_raw_cnt"}, cnt_raw, exp_raw);
    check_eq({tag, "_ferr_cnt"}, cnt_ferr, exp_ferr);
    check_eq({tag, "_tmo_cnt"}, cnt_tmo, exp_tmo);
    check_eq({tag, "_ovf_cnt"}, cnt_ovf, exp_ovf);
    check_eq({tag, "_bok_cnt"}, cnt_bok, exp_bok);
    check_eq({tag, "_berr_cnt"}, cnt_berr, exp_berr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int k, err;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", {key_valid, key_code, key_ext, key_break, raw_code, raw_stb},
             {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    check_eq("rst_pulses", {frame_err, timeout, overflow, bat_ok, bat_err}, 5'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    wait_ticks(4);

    // Plain make with KEY_VALID latency
    send_byte(8'h1C, 0);
    checkpoint("make1c");
    check_eq("valid_latency", valid_rise_cyc - stb_cyc, 1);

    // Extended break sequence
    send_byte(8'hE0, 0);
    send_f0();
    send_byte(8'h75, 0);
    checkpoint("ext_brk");

    // Parity error after F0 clears pending break
    send_f0();
    send_byte(8'h16, 1);
    send_byte(8'h16, 0);
    checkpoint("par_err");

    // Timeout on a partial frame
    send_bits(make_frame(8'h16, 0), 5);
    wait_ticks(TIMEOUT_TICKS + 10);
    exp_tmo++;
    send_byte(8'h16, 0);
    checkpoint("timeout");

    // Overflow with a stalled consumer
    @(negedge clk) key_ready = 1'b0;
    stalled = 1;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) send_byte(8'h15 + 8'(i), 0);
    wait_ticks(2);
    @(negedge clk);
    check_eq("stall_valid", key_valid, 1);
    check_eq("stall_head", {key_ext, key_break, key_code}, exp_q[0]);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("stall_head_hold", {key_ext, key_break, key_code}, exp_q[0]);
    stalled = 0;
    key_ready = 1'b1;
    checkpoint("overflow");

    // BAT codes in idle, FC as ordinary code after a prefix
    send_byte(8'hAA, 0);
    send_byte(8'hFC, 0);
    send_byte(8'hE0, 0);
    send_byte(8'hFC, 0);
    checkpoint("bat");

    // Reset in the middle of a frame
    send_bits(make_frame(8'h33, 0), 6);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_valid", key_valid, 0);
    check_eq("midrst_state", dbg_state, 2'd0);
    rst = 1'b0;
    m_ext = 0; m_brk = 0;
    send_byte(8'h1C, 0);
    wait_ticks(TIMEOUT_TICKS + 10);
    checkpoint("midrst");

    // Randomised sequences with a random consumer
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hAA;
        5:       b = 8'hFC;
        default: b = 8'($urandom_range(0, 255));
      endcase
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_any(b, err);
    end
    rand_ready = 0;
    @(posedge clk);
    #1 key_ready = 1'b1;
    checkpoint("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
